// File: rtl/fas.sv
// fas: streaming FIR -> 16-point DFT -> spectral peak finder.
//
// A 32-tap symmetric low-pass FIR filters 8.8 samples. Each group of 16 filtered samples is one
// frame. A frame's spectrum appears FFT_LAT cycles after its 16th fir_valid. The optional
// analysis stage reports the index of the bin with the highest power.
//
// Optional feature macro: FAS_ANALYSIS_EN
//   defined   -> power/argmax stage built; done/freq follow each frame.
//   undefined -> no analysis logic; done and freq are tied to 0.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-low reset
//   data_valid, data  input sample strobe and signed 8.8 sample
//   fir_valid, fir_d  filtered sample strobe and signed 8.8 value (held between strobes)
//   fft_valid         one-cycle strobe when fft_d0..fft_d15 update
//   fft_d0..fft_d15   bin k: [31:16] real, [15:0] imaginary, signed 8.8
//   done, freq        one-cycle strobe and peak bin index of the latest frame
module fas #(
  parameter int unsigned TAPS    = 32,
  parameter int unsigned NFFT    = 16,
  parameter int unsigned FFT_LAT = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [15:0] data,
  output logic        fir_valid,
  output logic [15:0] fir_d,
  output logic        fft_valid,
  output logic [31:0] fft_d0,
  output logic [31:0] fft_d1,
  output logic [31:0] fft_d2,
  output logic [31:0] fft_d3,
  output logic [31:0] fft_d4,
  output logic [31:0] fft_d5,
  output logic [31:0] fft_d6,
  output logic [31:0] fft_d7,
  output logic [31:0] fft_d8,
  output logic [31:0] fft_d9,
  output logic [31:0] fft_d10,
  output logic [31:0] fft_d11,
  output logic [31:0] fft_d12,
  output logic [31:0] fft_d13,
  output logic [31:0] fft_d14,
  output logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq
);

  localparam int unsigned AccW = 42;

  // Symmetric low-pass coefficients, signed 4.16; c[i] = c[31-i].
  function automatic logic signed [19:0] fir_coef(input int unsigned i);
    int unsigned j;
    j = (i < 16) ? i : 31 - i;
    case (j)
      0:       fir_coef = -20'sd60;
      1:       fir_coef = -20'sd90;
      2:       fir_coef = -20'sd110;
      3:       fir_coef = -20'sd100;
      4:       fir_coef = -20'sd40;
      5:       fir_coef = 20'sd80;
      6:       fir_coef = 20'sd260;
      7:       fir_coef = 20'sd480;
      8:       fir_coef = 20'sd900;
      9:       fir_coef = 20'sd1400;
      10:      fir_coef = 20'sd2000;
      11:      fir_coef = 20'sd2700;
      12:      fir_coef = 20'sd3500;
      13:      fir_coef = 20'sd4300;
      14:      fir_coef = 20'sd5000;
      default: fir_coef = 20'sd5400;
    endcase
  endfunction

  // cos(2*pi*m/16) in signed 4.16.
  function automatic logic signed [19:0] tw_cos(input logic [3:0] m);
    case (m)
      4'd0:    tw_cos = 20'sd65536;
      4'd1:    tw_cos = 20'sd60547;
      4'd2:    tw_cos = 20'sd46341;
      4'd3:    tw_cos = 20'sd25080;
      4'd4:    tw_cos = 20'sd0;
      4'd5:    tw_cos = -20'sd25080;
      4'd6:    tw_cos = -20'sd46341;
      4'd7:    tw_cos = -20'sd60547;
      4'd8:    tw_cos = -20'sd65536;
      4'd9:    tw_cos = -20'sd60547;
      4'd10:   tw_cos = -20'sd46341;
      4'd11:   tw_cos = -20'sd25080;
      4'd12:   tw_cos = 20'sd0;
      4'd13:   tw_cos = 20'sd25080;
      4'd14:   tw_cos = 20'sd46341;
      default: tw_cos = 20'sd60547;
    endcase
  endfunction

  logic signed [15:0]     hist_q [TAPS-1];  // x[n-1] .. x[n-31]
  logic [3:0]             smp_cnt_q;
  logic signed [15:0]     frame_q [NFFT];
  logic signed [15:0]     dft_in_q [NFFT];  // completed frame, stable until its result is out
  logic [3:0]             lat_cnt_q;
  logic [31:0]            fft_q [NFFT];

  logic signed [AccW-1:0] fir_acc;
  logic signed [AccW-1:0] fir_rnd;
  logic signed [15:0]     fir_next;

  logic signed [AccW-1:0] re_acc [NFFT];
  logic signed [AccW-1:0] im_acc [NFFT];
  logic [31:0]            bin_next [NFFT];
  logic [3:0]             tw_idx;

  // FIR sum over the incoming sample and the 31 stored ones, 24 fraction bits.
  always_comb begin
    fir_acc = AccW'(fir_coef(0)) * AccW'($signed(data));
    for (int i = 1; i < TAPS; i++) begin
      fir_acc = fir_acc + AccW'(fir_coef(i)) * AccW'(hist_q[i-1]);
    end
    // Bias negative sums so the arithmetic shift rounds toward zero.
    fir_rnd  = fir_acc[AccW-1] ? fir_acc + AccW'(65535) : fir_acc;
    fir_next = 16'(fir_rnd >>> 16);
  end

  // Direct DFT of the held frame; -sin(theta) is taken as cos(theta + pi/2).
  always_comb begin
    tw_idx = '0;
    for (int k = 0; k < NFFT; k++) begin
      re_acc[k] = '0;
      im_acc[k] = '0;
      for (int n = 0; n < NFFT; n++) begin
        tw_idx    = 4'(n * k);
        re_acc[k] = re_acc[k] + AccW'(dft_in_q[n]) * AccW'(tw_cos(tw_idx));
        im_acc[k] = im_acc[k] + AccW'(dft_in_q[n]) * AccW'(tw_cos(tw_idx + 4'd4));
      end
      bin_next[k] = {16'(re_acc[k] >>> 16), 16'(im_acc[k] >>> 16)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS - 1; i++) hist_q[i] <= '0;
      for (int k = 0; k < NFFT; k++) begin
        frame_q[k]  <= '0;
        dft_in_q[k] <= '0;
        fft_q[k]    <= '0;
      end
      smp_cnt_q <= '0;
      lat_cnt_q <= '0;
      fir_valid <= 1'b0;
      fir_d     <= '0;
      fft_valid <= 1'b0;
    end else begin
      fir_valid <= data_valid;
      fft_valid <= 1'b0;
      if (lat_cnt_q != 4'd0) begin
        lat_cnt_q <= lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) begin
          fft_valid <= 1'b1;
          for (int k = 0; k < NFFT; k++) fft_q[k] <= bin_next[k];
        end
      end
      if (data_valid) begin
        fir_d     <= fir_next;
        hist_q[0] <= $signed(data);
        for (int i = 1; i < TAPS - 1; i++) hist_q[i] <= hist_q[i-1];
        frame_q[smp_cnt_q] <= fir_next;
        smp_cnt_q <= smp_cnt_q + 4'd1;
        if (smp_cnt_q == 4'(NFFT - 1)) begin
          // Frames are >= 16 cycles apart and FFT_LAT <= 15, so the countdown is idle here.
          for (int n = 0; n < NFFT - 1; n++) dft_in_q[n] <= frame_q[n];
          dft_in_q[NFFT-1] <= fir_next;
          lat_cnt_q <= 4'(FFT_LAT);
        end
      end
    end
  end

  assign fft_d0  = fft_q[0];
  assign fft_d1  = fft_q[1];
  assign fft_d2  = fft_q[2];
  assign fft_d3  = fft_q[3];
  assign fft_d4  = fft_q[4];
  assign fft_d5  = fft_q[5];
  assign fft_d6  = fft_q[6];
  assign fft_d7  = fft_q[7];
  assign fft_d8  = fft_q[8];
  assign fft_d9  = fft_q[9];
  assign fft_d10 = fft_q[10];
  assign fft_d11 = fft_q[11];
  assign fft_d12 = fft_q[12];
  assign fft_d13 = fft_q[13];
  assign fft_d14 = fft_q[14];
  assign fft_d15 = fft_q[15];

`ifdef FAS_ANALYSIS_EN
  logic signed [33:0] pwr [NFFT];
  logic signed [33:0] re_w;
  logic signed [33:0] im_w;
  logic signed [33:0] best_pwr;
  logic [3:0]         best_idx;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    re_w     = '0;
    im_w     = '0;
    for (int k = 0; k < NFFT; k++) begin
      re_w   = 34'($signed(fft_q[k][31:16]));
      im_w   = 34'($signed(fft_q[k][15:0]));
      pwr[k] = re_w * re_w + im_w * im_w;
    end
    best_pwr = pwr[0];
    best_idx = '0;
    for (int k = 1; k < NFFT; k++) begin
      if (pwr[k] > best_pwr) begin
        best_pwr = pwr[k];
        best_idx = 4'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      done <= 1'b0;
      freq <= '0;
    end else begin
      done <= fft_valid;
      if (fft_valid) freq <= best_idx;
    end
  end
`else
  assign done = 1'b0;
  assign freq = '0;
`endif

endmodule

// File: tb/tb_fas.sv
// Scoreboard bench for fas: the driver pushes expected FIR samples and expected spectra (from a
// reference model) into queues; a negedge monitor pops and compares them against DUT output.
module tb_fas;

  localparam int unsigned FFT_LAT = 12;
  localparam real Pi = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] data = '0;
  logic        fir_valid, fft_valid, done;
  logic [15:0] fir_d;
  logic [3:0]  freq;
  logic [31:0] fft_arr [16];

  fas #(.TAPS(32), .NFFT(16), .FFT_LAT(FFT_LAT)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
    .fir_valid(fir_valid), .fir_d(fir_d), .fft_valid(fft_valid),
    .fft_d0(fft_arr[0]), .fft_d1(fft_arr[1]), .fft_d2(fft_arr[2]), .fft_d3(fft_arr[3]),
    .fft_d4(fft_arr[4]), .fft_d5(fft_arr[5]), .fft_d6(fft_arr[6]), .fft_d7(fft_arr[7]),
    .fft_d8(fft_arr[8]), .fft_d9(fft_arr[9]), .fft_d10(fft_arr[10]), .fft_d11(fft_arr[11]),
    .fft_d12(fft_arr[12]), .fft_d13(fft_arr[13]), .fft_d14(fft_arr[14]), .fft_d15(fft_arr[15]),
    .done(done), .freq(freq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    n_vec++;
    if (got > exp + tol || got < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
    end
  endtask

  // Reference coefficient table (4.16), symmetric.
  function automatic int coef(input int i);
    int h[16] = '{-60, -90, -110, -100, -40, 80, 260, 480,
                  900, 1400, 2000, 2700, 3500, 4300, 5000, 5400};
    return (i < 16) ? h[i] : h[31 - i];
  endfunction

  function automatic int fold(input int k);
    return (k <= 8) ? k : 16 - k;
  endfunction

  // Reference model state and scoreboard queues.
  int     hist [32];
  int     fr_vals [16];
  int     fr_cnt;
  int     exp_fir_q [$];
  int     exp_fft_q [$];  // re0, im0, re1, im1, ... per frame
  longint exp_cyc_q [$];
  int     exp_fold_q [$];
  bit     exp_fchk_q [$];
  longint cyc = 0;

  always @(posedge clk) cyc++;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) hist[i] = 0;
    fr_cnt = 0;
    exp_fir_q.delete();
    exp_fft_q.delete();
    exp_cyc_q.delete();
    exp_fold_q.delete();
    exp_fchk_q.delete();
  endtask

  task automatic model_push(input logic [15:0] d);
    longint s;
    logic [15:0] y;
    int yi;
    real re, im, ang;
    real pw [9];
    int best;
    real second;
    for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'($signed(d));
    s = 0;
    for (int i = 0; i < 32; i++) s += longint'(coef(i)) * longint'(hist[i]);
    if (s < 0) s += 65535;
    s = s >>> 16;
    y = s[15:0];
    yi = int'($signed(y));
    exp_fir_q.push_back(yi);
    fr_vals[fr_cnt] = yi;
    fr_cnt++;
    if (fr_cnt == 16) begin
      fr_cnt = 0;
      for (int k = 0; k < 16; k++) begin
        re = 0.0;
        im = 0.0;
        for (int n = 0; n < 16; n++) begin
          ang = 2.0 * Pi * real'(n * k) / 16.0;
          re += real'(fr_vals[n]) * $cos(ang);
          im -= real'(fr_vals[n]) * $sin(ang);
        end
        exp_fft_q.push_back(int'(re));
        exp_fft_q.push_back(int'(im));
        if (k <= 8) pw[k] = re * re + im * im;
      end
      best = 0;
      for (int f = 1; f <= 8; f++) if (pw[f] > pw[best]) best = f;
      second = 0.0;
      for (int f = 0; f <= 8; f++) if (f != best && pw[f] > second) second = pw[f];
      exp_fold_q.push_back(best);
      // Only judge the peak when it is clearly above every other folded bin.
      exp_fchk_q.push_back(pw[best] > 2.0 * second && pw[best] > 400.0);
      exp_cyc_q.push_back(cyc + 1 + longint'(FFT_LAT));
    end
  endtask

  task automatic step(input bit v, input logic [15:0] d);
    @(posedge clk);
    #2;
    data_valid = v;
    data       = d;
    if (v) model_push(d);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst        = 1'b0;
    data_valid = 1'b0;
    @(posedge clk);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  function automatic logic [15:0] tone(input int n);
    int iv;
    iv = int'(256.0 * $cos(2.0 * Pi * real'(n) / 16.0));
    return 16'(iv);
  endfunction

  // Monitor: samples outputs mid-cycle.
  logic exp_fv = 1'b0;
  logic rst_seen = 1'b1;
  int   last_fir = 0;
  bit   prev_fft = 1'b0;
  int   pend_fold = 0;
  bit   pend_chk = 1'b0;

  always @(posedge clk) begin
    exp_fv   <= rst & data_valid;
    rst_seen <= ~rst;
  end

  always @(negedge clk) begin
    int e, ere, eim;
    longint ec;
    if (rst_seen) begin
      check("rst_fir_valid", fir_valid, 0, 0);
      check("rst_fir_d", fir_d, 0, 0);
      check("rst_fft_valid", fft_valid, 0, 0);
      check("rst_done", done, 0, 0);
      check("rst_freq", freq, 0, 0);
      for (int k = 0; k < 16; k++) check($sformatf("rst_fft_d%0d", k), fft_arr[k], 0, 0);
      last_fir = 0;
      prev_fft = 1'b0;
      pend_chk = 1'b0;
    end else begin
      check("fir_valid", fir_valid, exp_fv, 0);
      if (fir_valid) begin
        if (exp_fir_q.size() == 0) check("fir_unexpected", 1, 0, 0);
        else begin
          e = exp_fir_q.pop_front();
          check("fir_d", int'($signed(fir_d)), e, 0);
          last_fir = e;
        end
      end else begin
        check("fir_hold", int'($signed(fir_d)), last_fir, 0);
      end
`ifdef FAS_ANALYSIS_EN
      check("done", done, prev_fft, 0);
      if (prev_fft && pend_chk) check("freq_fold", fold(int'(freq)), pend_fold, 0);
`else
      check("done_off", done, 0, 0);
      check("freq_off", freq, 0, 0);
`endif
      if (fft_valid) begin
        if (exp_cyc_q.size() == 0) check("fft_unexpected", 1, 0, 0);
        else begin
          ec = exp_cyc_q.pop_front();
          check("fft_latency", cyc, ec, 0);
          for (int k = 0; k < 16; k++) begin
            ere = exp_fft_q.pop_front();
            eim = exp_fft_q.pop_front();
            check($sformatf("fft_re%0d", k), int'($signed(fft_arr[k][31:16])), ere, 3);
            check($sformatf("fft_im%0d", k), int'($signed(fft_arr[k][15:0])), eim, 3);
          end
          pend_fold = exp_fold_q.pop_front();
          pend_chk  = exp_fchk_q.pop_front();
        end
      end
      prev_fft = fft_valid;
    end
  end

  initial begin
    model_reset();
    apply_reset();

    // Impulse, then zeros past the delay line length.
    step(1'b1, 16'h0100);
    for (int n = 0; n < 40; n++) step(1'b1, 16'h0000);

    // DC input: several frames, later ones steady.
    apply_reset();
    for (int n = 0; n < 64; n++) step(1'b1, 16'h0100);

    // Bin-1 tone with gaps carrying junk data.
    apply_reset();
    for (int n = 0; n < 64; n++) begin
      step(1'b1, tone(n));
      step(1'b0, 16'h5a5a);
    end

    // Same tone without gaps, then reset 7 samples into the second frame.
    apply_reset();
    for (int n = 0; n < 23; n++) step(1'b1, tone(n));
    apply_reset();

    // Long tone run after the mid-frame reset: 64 frames.
    for (int n = 0; n < 1024; n++) step(1'b1, tone(n));
    for (int n = 0; n < 40; n++) step(1'b0, 16'h0000);

    check("fir_pending", exp_fir_q.size(), 0, 0);
    check("fft_pending", exp_cyc_q.size(), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
